// File: rtl/regfile_pkg.sv
// Shared register-file constants: address/data widths, register count,
// the hard-wired zero register and the conflict counter width.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  localparam int CNT_W    = 16;
endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches the valid vector
// starting at ptr, wrapping modulo NUM_REQ, and returns the first hit as a
// one-hot grant, its index, and an any_grant flag.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Walk offsets from farthest to nearest so the nearest valid source wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// NUM_REQ writeback sources with round-robin arbitration.
// Handshake: a source transfers when req_valid[i] & req_ready[i] in the same
// cycle; valid/addr/data are held stable until accepted, valid never waits on
// ready, and at most one ready bit is high per cycle (none during reset).
// Optional read-port forwarding is enabled by defining REGFILE_ARB_FWD_EN.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [ADDR_W-1:0]         rd_addr_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [2**ADDR_W-1:0]      write_onehot,
  output logic [15:0]               conflict_count
);
  import regfile_pkg::REG_ZERO;
  import regfile_pkg::CNT_W;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                any_grant;
  logic                accept;
  logic                real_write;
  logic                conflict;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [2**ADDR_W-1:0] sel_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Nothing is accepted while reset is high.
  assign req_ready  = reset ? '0 : grant;
  assign accept     = any_grant & ~reset;
  assign sel_addr   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data   = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  // r0 writes complete the handshake but never reach the port.
  assign real_write = accept & (sel_addr != ADDR_W'(REG_ZERO));
  assign ptr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign conflict   = ($countones(req_valid) >= 2);

  // Decode the selected address so the one-hot vector can be registered.
  always_comb begin
    sel_onehot           = '0;
    sel_onehot[sel_addr] = 1'b1;
  end

  // Pointer, write-port registers and saturating conflict counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr              <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      write_onehot     <= '0;
      conflict_count   <= '0;
    end else begin
      if (accept) ptr <= ptr_next;
      ctrl_writeEnable <= real_write;
      write_onehot     <= real_write ? sel_onehot : '0;
      if (real_write) begin
        ctrl_writeReg <= sel_addr;
        data_writeReg <= sel_data;
      end
      if (conflict && (conflict_count != CNT_MAX)) conflict_count <= conflict_count + 1'b1;
    end
  end

`ifdef REGFILE_ARB_FWD_EN
  // Bypass the value currently on the write port to the two read ports.
  assign fwd_hit_a  = ctrl_writeEnable & (rd_addr_a == ctrl_writeReg) & (rd_addr_a != ADDR_W'(REG_ZERO));
  assign fwd_hit_b  = ctrl_writeEnable & (rd_addr_b == ctrl_writeReg) & (rd_addr_b != ADDR_W'(REG_ZERO));
  assign fwd_data_a = fwd_hit_a ? data_writeReg : '0;
  assign fwd_data_b = fwd_hit_b ? data_writeReg : '0;
`endif

endmodule
